toggle_activity_monitor: RTL and testbench

- Sequential measurement stage directly downstream of a combinational cell under test, e.g. the Q output of an AO221X1 instance.
- Counts rising and falling transitions and high-level cycles of that output over a programmed window of CLK cycles.
- These counts give switching activity and static probability for power characterisation of the cell.
- Sits between the cell-under-test output and the bench/readout logic; its start/done handshake is driven by the stimulus sequencer.

---
 rtl/toggle_activity_monitor.sv | 69 ++++++
 tb/tb_toggle_activity_monitor.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/toggle_activity_monitor.sv
// toggle_activity_monitor: counts rising/falling edges and high cycles of a cell output over a programmed window.
module toggle_activity_monitor #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIN_W-1:0] i_window,
  input  logic             i_din,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_rise_cnt,
  output logic [CNT_W-1:0] o_fall_cnt,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic             o_ovf
);
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS, S_DONE} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t r_state, w_next;
  logic [WIN_W-1:0] r_rem;
  logic r_prev, r_ovf;
  logic [CNT_W-1:0] r_rise, r_fall, r_high;
  logic w_rise, w_fall, w_high, w_sat;
  always_comb begin
    w_next = r_state == S_IDLE ? (i_start ? (i_window == '0 ? S_DONE : S_ARM) : S_IDLE) :
             r_state == S_ARM  ? S_MEAS :
             r_state == S_MEAS ? (r_rem == WIN_W'(1) ? S_DONE : S_MEAS) : S_IDLE;
    w_rise = i_din & ~r_prev;
    w_fall = ~i_din & r_prev;
    w_high = i_din;
    w_sat  = (w_rise && r_rise == CNT_MAX) || (w_fall && r_fall == CNT_MAX) || (w_high && r_high == CNT_MAX);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_prev  <= 1'b0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_high  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_start) begin
        r_rem  <= i_window;
        r_rise <= '0;
        r_fall <= '0;
        r_high <= '0;
        r_ovf  <= 1'b0;
      end else if (r_state == S_ARM) begin
        r_prev <= i_din;
      end else if (r_state == S_MEAS) begin
        r_prev <= i_din;
        r_rem  <= r_rem - 1'b1;
        if (w_rise && r_rise != CNT_MAX) r_rise <= r_rise + 1'b1;
        if (w_fall && r_fall != CNT_MAX) r_fall <= r_fall + 1'b1;
        if (w_high && r_high != CNT_MAX) r_high <= r_high + 1'b1;
        if (w_sat) r_ovf <= 1'b1;
      end
    end
  end
  assign o_busy     = r_state == S_ARM || r_state == S_MEAS;
  assign o_done     = r_state == S_DONE;
  assign o_rise_cnt = r_rise;
  assign o_fall_cnt = r_fall;
  assign o_high_cnt = r_high;
  assign o_ovf      = r_ovf;
endmodule

// File: tb/tb_toggle_activity_monitor.sv
// tb_toggle_activity_monitor: random and directed windows checked by a DONE-triggered scoreboard.
module tb_toggle_activity_monitor;
  localparam int CNT_W = 4;
  localparam int WIN_W = 16;
  localparam int SAT = (1 << CNT_W) - 1;
  typedef struct {int r; int f; int h; bit o;} res_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, din = 1'b0;
  logic [WIN_W-1:0] window = '0;
  logic busy, done, ovf;
  logic [CNT_W-1:0] rise_cnt, fall_cnt, high_cnt;
  res_t sb[$];
  res_t last;
  bit have_last = 1'b0;
  bit pat[64];
  int vectors = 0, miscompares = 0;

  toggle_activity_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_window(window), .i_din(din),
    .o_busy(busy), .o_done(done), .o_rise_cnt(rise_cnt), .o_fall_cnt(fall_cnt),
    .o_high_cnt(high_cnt), .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: raw transition/high counts over the window, then clamp.
  function automatic res_t model(input int w, input bit arm);
    res_t m;
    int rr = 0, ff = 0, hh = 0;
    for (int k = 0; k < w; k++) begin
      bit p = (k == 0) ? arm : pat[k-1];
      rr += int'(pat[k] && !p);
      ff += int'(!pat[k] && p);
      hh += int'(pat[k]);
    end
    m.r = rr > SAT ? SAT : rr;
    m.f = ff > SAT ? SAT : ff;
    m.h = hh > SAT ? SAT : hh;
    m.o = rr > SAT || ff > SAT || hh > SAT;
    return m;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) chk("stray_done", 1, 0);
        else begin
          res_t e;
          e = sb.pop_front();
          chk("rise", rise_cnt, e.r);
          chk("fall", fall_cnt, e.f);
          chk("high", high_cnt, e.h);
          chk("ovf", ovf, e.o);
          chk("busy_in_done", busy, 0);
          last = e;
          have_last = 1'b1;
        end
      end else if (!busy && have_last) begin
        chk("hold_rise", rise_cnt, last.r);
        chk("hold_fall", fall_cnt, last.f);
        chk("hold_high", high_cnt, last.h);
        chk("hold_ovf", ovf, last.o);
      end
    end
  end

  // Called at a negedge with the DUT idle.
  task automatic meas(input int w, input bit arm, input bit extra);
    sb.push_back(model(w, arm));
    start = 1'b1;
    window = WIN_W'(w);
    @(negedge clk);
    start = 1'b0;
    window = WIN_W'($urandom);
    din = arm;
    chk("busy_after_start", busy, w != 0);
    if (w == 0) chk("done_zero_window", done, 1);
    else begin
      @(negedge clk);
      for (int k = 0; k < w; k++) begin
        din = pat[k];
        start = extra && k == w / 2;
        window = WIN_W'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
      chk("done_timing", done, 1);
    end
    repeat (2) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    res_t z;
    z = '{0, 0, 0, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnts", {rise_cnt, fall_cnt, high_cnt, ovf}, 0);
    last = z;
    have_last = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) pat[k] = ~k[0];
    meas(8, 1'b0, 1'b0);
    meas(0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) pat[k] = 1'b1;
    meas(5, 1'b1, 1'b1);
    for (int k = 0; k < 40; k++) pat[k] = ~k[0];
    meas(40, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) pat[k] = (k == 2);
    meas(10, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    for (int k = 0; k < 20; k++) pat[k] = ~k[0];
    start = 1'b1;
    window = 16'd20;
    @(negedge clk);
    start = 1'b0;
    din = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      din = pat[k];
    end
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_cnts", {rise_cnt, fall_cnt, high_cnt, ovf}, 0);
    last = z;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 6; k++) pat[k] = (k == 1 || k == 2);
    meas(6, 1'b1, 1'b0);
    for (int n = 0; n < 30; n++) begin
      int w;
      w = $urandom_range(0, 40);
      for (int k = 0; k < w; k++) pat[k] = 1'($urandom);
      meas(w, 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
